mod_buzz_seq: RTL
=================

MOD_BUZZ_SEQ -- requirements
Module: mod_buzz_seq

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter GAP_W, default 16: width of the inter-beep gap counter, in microseconds.
REQ-003 SHALL have parameter BUSY_TO, default 16: clk_i cycles to wait for buz_busy_i to rise after a trigger.
REQ-004 clk_i  in  1  core clock; the one clock for the whole block.
REQ-005 rst_i  in  1  reset, synchronous and active-low.
REQ-006 tick_i  in  1  single-cycle 1 us strobe, synchronous to clk_i.
REQ-007 req_i  in  NUM_REQ  level beep request, one bit per requester.
REQ-008 cnt_i  in  NUM_REQ x 4  number of beeps per requester.
REQ-009 gap_us_i  in  GAP_W  silence between beeps, in us; shared by all requesters.
REQ-010 ack_o  in/out: out  NUM_REQ  one-cycle pulse when a request is accepted.
REQ-011 done_o  out  NUM_REQ  one-cycle pulse when the granted sequence completes.
REQ-012 gnt_id_o  out  $clog2(NUM_REQ)  index of the granted requester; valid while busy_o=1.
REQ-013 busy_o  out  1  a sequence is in progress.
REQ-014 buz_trig_o  out  1  one-cycle trigger to the buzzer.
REQ-015 buz_busy_i  in  1  buzzer cycle-in-progress indication.
REQ-016 err_o  out  1  sticky flag: the buzzer did not respond within BUSY_TO.

Function
REQ-017 States SHALL be IDLE, TRIG, WAIT_RISE, WAIT_FALL, GAP and DONE.
REQ-018 IDLE: when any req_i bit is set and buz_busy_i=0, the arbiter picks a winner, the block latches its id and cnt_i, and ack_o[id] pulses in the same cycle.
  - Next state is TRIG.
  - If the latched count is 0, next state is DONE instead.
REQ-019 TRIG: buz_trig_o=1 for exactly one cycle, then WAIT_RISE.
REQ-020 WAIT_RISE: buz_busy_i=1 moves to WAIT_FALL.
  - After BUSY_TO cycles without a rise, set err_o and go to DONE.
REQ-021 WAIT_FALL: buz_busy_i=0 decrements the remaining count.
  - Remaining count 0 goes to DONE.
  - Otherwise, gap_us_i=0 goes to TRIG; any other value goes to GAP.
REQ-022 GAP: the gap counter loads gap_us_i on entry and decrements on each tick_i; reaching 0 goes to TRIG.
REQ-023 DONE: done_o[id] pulses for one cycle, then IDLE; a new grant is possible the cycle after.
REQ-024 busy_o=1 in every state except IDLE.
REQ-025 cnt_i and gap_us_i are sampled as follows:
  - cnt_i only at grant.
  - gap_us_i at each entry to GAP.
  - Changing either mid-sequence does not alter the current beep count.
REQ-026 Dropping req_i mid-sequence SHALL NOT abort; the sequence runs to completion.
REQ-027 A requester still holding req_i after done_o is eligible again.
REQ-028 Arbitration: a grant needs an idle state machine AND buz_busy_i=0.
  - buz_busy_i=1 in IDLE, e.g. from an external trigger, blocks the grant.
REQ-029 Arithmetic: the gap counter is GAP_W bits and never wraps (it stops at 0); the beep counter is 4 bits, 0..15.
REQ-030 A tick_i arriving in the same cycle as GAP entry SHALL NOT be counted.

Reset
REQ-031 With rst_i=0 at a clk_i edge, every output SHALL be 0 and the state SHALL be IDLE.
  - Applies to ack_o, done_o, gnt_id_o, busy_o, buz_trig_o and err_o.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no done_o pulse.
REQ-033 err_o SHALL clear only on reset.

Configuration
REQ-034 With MOD_BUZZ_SEQ_RR_EN defined, arbitration SHALL be round-robin.
  - The search starts at the requester after the last grant.
  - The pointer resets to 0 and updates only on ack_o.
REQ-035 Without MOD_BUZZ_SEQ_RR_EN, arbitration SHALL be fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-036 Package buzz_seq_pkg SHALL hold:
  - the state enum;
  - the 4-bit count type;
  - the default constants NUM_REQ_DEF and BUSY_TO_DEF.
REQ-037 Arbitration SHALL live in sub-module mod_buzz_arb.
  - Inputs: req vector and enable; outputs: one-hot grant and index.
  - Contains the RR pointer when MOD_BUZZ_SEQ_RR_EN is defined.

Verification
REQ-038 Single requester: req_i[1]=1, cnt=3, gap=2, with a buzzer model that goes busy 2 cycles after trigger for 5 cycles.
  - Expect 3 buz_trig_o pulses, each gap being 2 ticks.
  - Expect done_o[1] after the 3rd fall.
REQ-039 Simultaneous req_i=4'b1010 held.
  - Fixed priority: grants 1,1,1...
  - RR build: grants 1,3,1,3.
REQ-040 cnt=0: ack_o then done_o two cycles later, with no buz_trig_o.
REQ-041 Buzzer model never asserts busy: err_o rises BUSY_TO+1 cycles after the trigger, followed by done_o.
REQ-042 rst_i=0 during GAP of a 4-beep sequence: all outputs are 0 the next cycle and no done_o is seen.
  - A fresh request after release starts a full 4-beep sequence.

Source files
------------

// File: rtl/mod_buzz_seq_pkg.sv
// Shared types and defaults for the buzzer beep sequencer.
package buzz_seq_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int BUSY_TO_DEF = 16;

   // Beep count, 0..15
   typedef logic [3:0] cnt_t;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      WAIT_FALL,
      GAP,
      DONE
   } state_t;

endpackage

// File: rtl/mod_buzz_arb.sv
// Requester arbiter for the buzzer sequencer.
// MOD_BUZZ_SEQ_RR_EN defined: round-robin, search starts after the last grant.
// MOD_BUZZ_SEQ_RR_EN undefined: fixed priority, lowest index wins.
module mod_buzz_arb
   import buzz_seq_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
`ifdef MOD_BUZZ_SEQ_RR_EN
   input  logic                       clk_i,
   input  logic                       rst_i,
`endif
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic                       en_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

`ifdef MOD_BUZZ_SEQ_RR_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Pick the first requester at or after the pointer, wrapping around
   always_comb begin
      logic             found;
      int unsigned      cand;
      logic [IDX_W-1:0] cand_idx;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      gnt_o    = '0;
      idx_o    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (en_i && !found && req_i[cand_idx]) begin
            found         = 1'b1;
            gnt_o         = '0;
            gnt_o[cand_idx] = 1'b1;
            idx_o         = cand_idx;
         end
      end
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (int'(idx_o) == NUM_REQ - 1) ? '0 : idx_o + IDX_W'(1);
      end
   end

   // Pointer advances only when a grant is issued
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: lowest set request bit wins
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand_idx;
      found    = 1'b0;
      cand_idx = '0;
      gnt_o    = '0;
      idx_o    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand_idx = IDX_W'(i);
         if (en_i && !found && req_i[cand_idx]) begin
            found           = 1'b1;
            gnt_o[cand_idx] = 1'b1;
            idx_o           = cand_idx;
         end
      end
   end
`endif

endmodule

// File: rtl/mod_buzz_seq.sv
// Buzzer beep sequencer: arbitrates requesters, then plays cnt beeps with a
// microsecond-timed gap, supervising the buzzer busy handshake.
// Optional: MOD_BUZZ_SEQ_RR_EN selects round-robin arbitration.
module mod_buzz_seq
   import buzz_seq_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int GAP_W   = 16,
   parameter int BUSY_TO = BUSY_TO_DEF
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       tick_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ-1:0][3:0]    cnt_i,
   input  logic [GAP_W-1:0]           gap_us_i,
   output logic [NUM_REQ-1:0]         ack_o,
   output logic [NUM_REQ-1:0]         done_o,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
   output logic                       busy_o,
   output logic                       buz_trig_o,
   input  logic                       buz_busy_i,
   output logic                       err_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TO_W  = $clog2(BUSY_TO + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   id_q, id_d;
   cnt_t               rem_q, rem_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [TO_W-1:0]    wait_q, wait_d;
   logic               err_q, err_d;
   logic [NUM_REQ-1:0] done_q, done_d;

   logic               arb_en;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               granted;
   logic               rem_last;
   logic               gap_last;
   logic               rise_to;

   // rst_i also gates the combinational grant so ack_o stays low while reset is held
   assign arb_en   = (state_q == IDLE) && !buz_busy_i && rst_i;
   assign granted  = |arb_gnt;
   assign rem_last = (rem_q <= cnt_t'(1));
   assign gap_last = (gap_q <= GAP_W'(1));
   assign rise_to  = (wait_q == TO_LAST);

   mod_buzz_arb #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef MOD_BUZZ_SEQ_RR_EN
      .clk_i (clk_i),
      .rst_i (rst_i),
`endif
      .req_i (req_i),
      .en_i  (arb_en),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (granted) begin
               state_d = (cnt_i[arb_idx] == '0) ? DONE : TRIG;
            end
         end
         TRIG: state_d = WAIT_RISE;
         WAIT_RISE: begin
            if (buz_busy_i) begin
               state_d = WAIT_FALL;
            end else if (rise_to) begin
               state_d = DONE;
            end
         end
         WAIT_FALL: begin
            if (!buz_busy_i) begin
               if (rem_last) begin
                  state_d = DONE;
               end else if (gap_us_i == '0) begin
                  state_d = TRIG;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (tick_i && gap_last) begin
               state_d = TRIG;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: grant latch, beep/gap/timeout counters, sticky error, done pulse
   always_comb begin
      id_d   = id_q;
      rem_d  = rem_q;
      gap_d  = gap_q;
      wait_d = wait_q;
      err_d  = err_q;
      done_d = '0;
      case (state_q)
         IDLE: begin
            if (granted) begin
               id_d  = arb_idx;
               rem_d = cnt_i[arb_idx];
            end
         end
         TRIG: wait_d = '0;
         WAIT_RISE: begin
            if (!buz_busy_i) begin
               if (rise_to) begin
                  err_d = 1'b1;
               end else begin
                  wait_d = wait_q + TO_W'(1);
               end
            end
         end
         WAIT_FALL: begin
            if (!buz_busy_i) begin
               if (rem_q != '0) begin
                  rem_d = rem_q - cnt_t'(1);
               end
               // Loading here means a tick in the entry cycle is never counted
               gap_d = gap_us_i;
            end
         end
         GAP: begin
            if (tick_i) begin
               gap_d = gap_last ? '0 : gap_q - GAP_W'(1);
            end
         end
         DONE:    done_d[id_q] = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         id_q   <= '0;
         rem_q  <= '0;
         gap_q  <= '0;
         wait_q <= '0;
         err_q  <= 1'b0;
         done_q <= '0;
      end else begin
         id_q   <= id_d;
         rem_q  <= rem_d;
         gap_q  <= gap_d;
         wait_q <= wait_d;
         err_q  <= err_d;
         done_q <= done_d;
      end
   end

   // Outputs
   always_comb begin
      ack_o      = arb_gnt;
      done_o     = done_q;
      gnt_id_o   = id_q;
      busy_o     = (state_q != IDLE);
      buz_trig_o = (state_q == TRIG);
      err_o      = err_q;
   end

endmodule
